router_fifo: RTL and testbench

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_pkg.sv | 18 +
 rtl/router_fifo.sv | 92 +++++++++
 tb/tb_router_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared sizing constants for the router output FIFOs
package router_pkg;

    localparam int ROUTER_DEPTH = 16;
    localparam int ROUTER_WIDTH = 8;
    localparam int CNT_W        = 6;

    // One extra wrap bit above the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // The header flag sits just above the payload byte in each entry.
    function automatic int hdr_bit(input int width);
        return width;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination router FIFO with header flag and packet counter
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = ROUTER_DEPTH,
    parameter int WIDTH = ROUTER_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam int HDR   = hdr_bit(WIDTH);

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [WIDTH:0]   mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             do_wr, do_rd;
    logic [WIDTH:0]   rd_entry;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign valid_out = ~empty;
    assign data_out  = data_out_q;

    always_comb begin
        do_wr      = write_enb & ~full;
        do_rd      = read_enb & ~empty;
        rd_entry   = mem_q[rd_ptr_q[AW-1:0]];
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;

        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = {lfd_state, data_in};
            wr_ptr_d                = wr_ptr_q + PTR_W'(1);
        end

        if (do_rd) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = rd_entry[WIDTH-1:0];
            // A header always reloads, abandoning any unfinished packet.
            if (rd_entry[HDR]) begin
                cnt_d = rd_entry[WIDTH-1 -: CNT_W] + CNT_W'(1);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (cnt_q == '0) begin
            data_out_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (soft_reset) begin
            // Flush leaves stale entries behind; the pointers make them unreachable.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - scoreboard bench for router_fifo
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn, soft_reset, write_enb, lfd_state, read_enb;
    logic [7:0] data_in, data_out;
    logic       valid_out, full, empty;

    int checks   = 0;
    int failures = 0;

    logic [8:0] model [$];
    logic [7:0] exp_q [$];

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                        input logic re, input logic srst, input logic rstn);
        logic [8:0] e;
        @(negedge clock);
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = srst;
        resetn     = rstn;
        if (!rstn || srst) begin
            model.delete();
        end else begin
            if (re && model.size() > 0) begin
                e = model.pop_front();
                exp_q.push_back(e[7:0]);
            end
            if (we && model.size() < 16 && !(re && model.size() == 0 && 1'b0)) begin
                model.push_back({lfd, din});
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        step(1'b1, lfd, din, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic hard_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: a read handshake outside reset must produce the next scoreboard byte.
    initial begin : monitor
        logic       fire;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            #2;
            fire = read_enb && valid_out && resetn && !soft_reset;
            @(posedge clock);
            #1;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected actual=%0h required=no_read", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_data", data_out, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        read_enb   = 1'b0;
        data_in    = 8'h00;

        hard_reset();
        hard_reset();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 8'h00);

        // Header 0D: length 3, counter loads 4.
        wr(1'b1, 8'h0D);
        wr(1'b0, 8'hA1);
        wr(1'b0, 8'hA2);
        wr(1'b0, 8'hA3);
        wr(1'b0, 8'h5F);
        check("pkt_valid", valid_out, 1);
        repeat (5) rd();
        idle();
        check("pkt_zero", data_out, 8'h00);
        check("pkt_empty", empty, 1);

        hard_reset();
        for (int i = 0; i < 15; i++) wr(1'b0, 8'h10 + 8'(i));
        check("fill15_full", full, 0);
        wr(1'b0, 8'h1F);
        check("fill16_full", full, 1);
        wr(1'b0, 8'hEE);
        check("drop_full", full, 1);
        repeat (16) rd();
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);

        hard_reset();
        for (int i = 0; i < 15; i++) wr(1'b0, 8'h40 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b1, 1'b0, 1'b1);
            check("rw_full", full, 0);
            check("rw_empty", empty, 0);
        end
        repeat (15) rd();
        check("rw_drain_empty", empty, 1);

        // Header leaves counter at 4 so data_out must hold across an empty read.
        hard_reset();
        wr(1'b1, 8'h0D);
        rd();
        rd();
        check("empty_rd_hold", data_out, 8'h0D);
        check("empty_rd_valid", valid_out, 0);
        wr(1'b0, 8'h11);
        rd();
        idle();
        check("cnt_hold", data_out, 8'h11);

        hard_reset();
        wr(1'b1, 8'h1C);
        for (int i = 0; i < 5; i++) wr(1'b0, 8'h20 + 8'(i));
        rd();
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1);
        check("srst_empty", empty, 1);
        check("srst_valid", valid_out, 0);
        check("srst_data", data_out, 8'h00);
        wr(1'b0, 8'h42);
        rd();
        check("srst_after_empty", empty, 1);

        hard_reset();
        wr(1'b1, 8'h09);
        wr(1'b0, 8'hC1);
        wr(1'b0, 8'hC2);
        wr(1'b0, 8'h3A);
        rd();
        rd();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("midrst_data", data_out, 8'h00);
        check("midrst_empty", empty, 1);
        check("midrst_valid", valid_out, 0);
        wr(1'b0, 8'h33);
        rd();
        idle();
        check("midrst_cnt_zero", data_out, 8'h00);
        wr(1'b1, 8'h05);
        wr(1'b0, 8'hB1);
        wr(1'b0, 8'h9E);
        repeat (3) rd();
        idle();
        check("midrst_pkt_zero", data_out, 8'h00);
        check("midrst_pkt_empty", empty, 1);

        repeat (2) idle();
        check("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
